// File: rtl/datapath_bus_mux_if.sv
// Bus-side signal bundle for datapath_bus_mux: source words, drive enables and
// the registered bus/status outputs.
interface datapath_bus_mux_if #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned NUM_SRC = 24,
    parameter int unsigned SEL_W   = $clog2(NUM_SRC),
    parameter int unsigned CNT_W   = 16
);
    logic [NUM_SRC*DATA_W-1:0] src_data;
    logic [NUM_SRC-1:0]        src_out;
    logic                      conflict_clr;
    logic [DATA_W-1:0]         bus_out;
    logic                      bus_valid;
    logic [SEL_W-1:0]          sel_idx;
    logic                      conflict;
    logic                      conflict_sticky;
    logic [CNT_W-1:0]          xfer_count;

    modport master (
        output src_data, src_out, conflict_clr,
        input  bus_out, bus_valid, sel_idx, conflict, conflict_sticky, xfer_count
    );

    modport slave (
        input  src_data, src_out, conflict_clr,
        output bus_out, bus_valid, sel_idx, conflict, conflict_sticky, xfer_count
    );
endinterface

// File: rtl/datapath_bus_mux.sv
// Priority-encoded datapath bus multiplexer with optional output register,
// idle-hold, sticky multi-drive detection and a saturating transfer counter.
module datapath_bus_mux #(
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned NUM_SRC      = 24,
    parameter int unsigned SEL_W        = $clog2(NUM_SRC),
    parameter int unsigned REG_OUT      = 1,
    parameter int unsigned HOLD_ON_IDLE = 1,
    parameter int unsigned CNT_W        = 16
) (
    input  logic               clock,
    input  logic               clear,
    datapath_bus_mux_if.slave  bif
);
    logic              any;
    logic              multi;
    logic [SEL_W-1:0]  win_idx;
    logic [DATA_W-1:0] win_data;

    logic [DATA_W-1:0] bus_d;
    logic [SEL_W-1:0]  idx_d;
    logic              valid_d;
    logic              conflict_d;

    logic [DATA_W-1:0] last_data_d, last_data_q;
    logic [SEL_W-1:0]  last_idx_d, last_idx_q;
    logic              sticky_d, sticky_q;
    logic [CNT_W-1:0]  cnt_d, cnt_q;

    // Lowest asserted enable wins.
    always_comb begin
        any      = 1'b0;
        win_idx  = '0;
        win_data = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (bif.src_out[i] && !any) begin
                any      = 1'b1;
                win_idx  = SEL_W'(i);
                win_data = bif.src_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign multi = |(bif.src_out & (bif.src_out - NUM_SRC'(1)));

    always_comb begin
        bus_d      = '0;
        idx_d      = '0;
        valid_d    = any;
        conflict_d = multi;
        if (any) begin
            bus_d = win_data;
            idx_d = win_idx;
        end else if (HOLD_ON_IDLE != 0) begin
            bus_d = last_data_q;
            idx_d = last_idx_q;
        end
    end

    always_comb begin
        last_data_d = any ? win_data : last_data_q;
        last_idx_d  = any ? win_idx  : last_idx_q;
        sticky_d    = sticky_q;
        if (multi)
            sticky_d = 1'b1;
        else if (bif.conflict_clr)
            sticky_d = 1'b0;
        cnt_d = (any && (cnt_q != '1)) ? cnt_q + CNT_W'(1) : cnt_q;
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            last_data_q <= '0;
            last_idx_q  <= '0;
            sticky_q    <= 1'b0;
            cnt_q       <= '0;
        end else begin
            last_data_q <= last_data_d;
            last_idx_q  <= last_idx_d;
            sticky_q    <= sticky_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bif.conflict_sticky = sticky_q;
    assign bif.xfer_count      = cnt_q;

    if (REG_OUT != 0) begin : g_reg
        logic [DATA_W-1:0] bus_q;
        logic [SEL_W-1:0]  idx_q;
        logic              valid_q;
        logic              conflict_q;

        always_ff @(posedge clock or negedge clear) begin
            if (!clear) begin
                bus_q      <= '0;
                idx_q      <= '0;
                valid_q    <= 1'b0;
                conflict_q <= 1'b0;
            end else begin
                bus_q      <= bus_d;
                idx_q      <= idx_d;
                valid_q    <= valid_d;
                conflict_q <= conflict_d;
            end
        end

        assign bif.bus_out   = bus_q;
        assign bif.sel_idx   = idx_q;
        assign bif.bus_valid = valid_q;
        assign bif.conflict  = conflict_q;
    end else begin : g_comb
        assign bif.bus_out   = bus_d;
        assign bif.sel_idx   = idx_d;
        assign bif.bus_valid = valid_d;
        assign bif.conflict  = conflict_d;
    end
endmodule

// File: tb/tb_datapath_bus_mux.sv
// Directed bench for datapath_bus_mux: default config, a 4-bit counter
// variant, and a combinational non-holding variant.
module tb_datapath_bus_mux;
    logic clock = 1'b0;
    logic clear = 1'b0;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clock = ~clock;

    datapath_bus_mux_if if0 ();
    datapath_bus_mux_if #(.CNT_W(4)) if1 ();
    datapath_bus_mux_if if2 ();

    datapath_bus_mux dut0 (.clock(clock), .clear(clear), .bif(if0));
    datapath_bus_mux #(.CNT_W(4)) dut1 (.clock(clock), .clear(clear), .bif(if1));
    datapath_bus_mux #(.REG_OUT(0), .HOLD_ON_IDLE(0)) dut2 (.clock(clock), .clear(clear), .bif(if2));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        if0.src_data = '0; if0.src_out = '0; if0.conflict_clr = 1'b0;
        if1.src_data = '0; if1.src_out = '0; if1.conflict_clr = 1'b0;
        if2.src_data = '0; if2.src_out = '0; if2.conflict_clr = 1'b0;

        // Reset held while R0 is driven
        if0.src_data[0 +: 32] = 32'hDEAD_BEEF;
        if0.src_out = 24'h000001;
        repeat (2) tick();
        chk("rst_bus",   32'(if0.bus_out), 32'h0);
        chk("rst_valid", 32'(if0.bus_valid), 32'h0);
        chk("rst_cnt",   32'(if0.xfer_count), 32'h0);

        if0.src_out = '0;
        clear = 1'b1;
        tick();
        chk("idle_bus",    32'(if0.bus_out), 32'h0);
        chk("idle_valid",  32'(if0.bus_valid), 32'h0);
        chk("idle_sel",    32'(if0.sel_idx), 32'h0);
        chk("idle_cnt",    32'(if0.xfer_count), 32'h0);
        chk("idle_sticky", 32'(if0.conflict_sticky), 32'h0);

        // Single drive from PC
        if0.src_data[20*32 +: 32] = 32'h0000_0040;
        if0.src_out = 24'h1 << 20;
        tick();
        chk("pc_bus",   32'(if0.bus_out), 32'h40);
        chk("pc_sel",   32'(if0.sel_idx), 32'd20);
        chk("pc_valid", 32'(if0.bus_valid), 32'h1);
        chk("pc_conf",  32'(if0.conflict), 32'h0);
        chk("pc_cnt",   32'(if0.xfer_count), 32'd1);
        if0.src_out = '0;
        tick();
        chk("hold_bus",   32'(if0.bus_out), 32'h40);
        chk("hold_valid", 32'(if0.bus_valid), 32'h0);
        chk("hold_sel",   32'(if0.sel_idx), 32'd20);
        chk("hold_cnt",   32'(if0.xfer_count), 32'd1);

        // Back-to-back MDR, ZLO, C
        if0.src_data[21*32 +: 32] = 32'h1234_5678;
        if0.src_data[19*32 +: 32] = 32'h0000_0009;
        if0.src_data[23*32 +: 32] = 32'hFFFF_FFF0;
        if0.src_out = 24'h1 << 21;
        tick();
        chk("b2b0_bus", 32'(if0.bus_out), 32'h1234_5678);
        chk("b2b0_sel", 32'(if0.sel_idx), 32'd21);
        if0.src_out = 24'h1 << 19;
        tick();
        chk("b2b1_bus", 32'(if0.bus_out), 32'h9);
        chk("b2b1_sel", 32'(if0.sel_idx), 32'd19);
        chk("b2b1_valid", 32'(if0.bus_valid), 32'h1);
        if0.src_out = 24'h1 << 23;
        tick();
        chk("b2b2_bus", 32'(if0.bus_out), 32'hFFFF_FFF0);
        chk("b2b2_sel", 32'(if0.sel_idx), 32'd23);
        chk("b2b_cnt",  32'(if0.xfer_count), 32'd4);
        if0.src_out = '0;
        tick();

        // Conflict R3 vs LO
        if0.src_data[3*32 +: 32]  = 32'h3;
        if0.src_data[17*32 +: 32] = 32'h17;
        if0.src_out = (24'h1 << 3) | (24'h1 << 17);
        tick();
        chk("cf_bus",    32'(if0.bus_out), 32'h3);
        chk("cf_sel",    32'(if0.sel_idx), 32'd3);
        chk("cf_flag",   32'(if0.conflict), 32'h1);
        chk("cf_sticky", 32'(if0.conflict_sticky), 32'h1);
        chk("cf_cnt",    32'(if0.xfer_count), 32'd5);
        if0.src_out = '0;
        tick();
        chk("cf_flag_drop", 32'(if0.conflict), 32'h0);
        chk("cf_sticky_hold", 32'(if0.conflict_sticky), 32'h1);
        chk("cf_hold_bus", 32'(if0.bus_out), 32'h3);
        if0.conflict_clr = 1'b1;
        tick();
        chk("cf_clr", 32'(if0.conflict_sticky), 32'h0);
        if0.src_out = (24'h1 << 3) | (24'h1 << 17);
        tick();
        chk("cf_set_wins", 32'(if0.conflict_sticky), 32'h1);
        chk("cf_cnt2",     32'(if0.xfer_count), 32'd6);
        if0.conflict_clr = 1'b0;
        if0.src_out = '0;
        tick();

        // Saturation on the 4-bit counter variant
        if1.src_data[1*32 +: 32] = 32'h11;
        if1.src_out = 24'h1 << 1;
        repeat (14) tick();
        chk("sat_e",   32'(if1.xfer_count), 32'hE);
        chk("sat_bus", 32'(if1.bus_out), 32'h11);
        tick();
        chk("sat_f",   32'(if1.xfer_count), 32'hF);
        repeat (5) tick();
        chk("sat_hold", 32'(if1.xfer_count), 32'hF);
        if1.src_out = '0;

        // Combinational, non-holding variant
        if2.src_data[5*32 +: 32] = 32'hA5A5_A5A5;
        if2.src_data[7*32 +: 32] = 32'h7777_7777;
        if2.src_out = 24'h1 << 5;
        #1;
        chk("comb_bus",   32'(if2.bus_out), 32'hA5A5_A5A5);
        chk("comb_sel",   32'(if2.sel_idx), 32'd5);
        chk("comb_valid", 32'(if2.bus_valid), 32'h1);
        if2.src_out = '0;
        #1;
        chk("comb_idle_bus", 32'(if2.bus_out), 32'h0);
        chk("comb_idle_sel", 32'(if2.sel_idx), 32'h0);
        chk("comb_idle_vld", 32'(if2.bus_valid), 32'h0);
        if2.src_out = (24'h1 << 5) | (24'h1 << 7);
        #1;
        chk("comb_cf",     32'(if2.conflict), 32'h1);
        chk("comb_cf_sel", 32'(if2.sel_idx), 32'd5);
        chk("comb_cf_pre", 32'(if2.conflict_sticky), 32'h0);
        tick();
        chk("comb_sticky", 32'(if2.conflict_sticky), 32'h1);
        chk("comb_cnt",    32'(if2.xfer_count), 32'd1);

        // Mid-cycle asynchronous clear while transfers are in flight
        if2.src_out = 24'h1 << 5;
        if0.src_out = 24'h1 << 21;
        #3;
        clear = 1'b0;
        #1;
        chk("aclr_bus",     32'(if0.bus_out), 32'h0);
        chk("aclr_valid",   32'(if0.bus_valid), 32'h0);
        chk("aclr_cnt",     32'(if0.xfer_count), 32'h0);
        chk("aclr_sticky0", 32'(if0.conflict_sticky), 32'h0);
        chk("aclr_sticky2", 32'(if2.conflict_sticky), 32'h0);
        chk("aclr_cnt2",    32'(if2.xfer_count), 32'h0);
        clear = 1'b1;
        tick();
        chk("post_bus",   32'(if0.bus_out), 32'h1234_5678);
        chk("post_valid", 32'(if0.bus_valid), 32'h1);
        chk("post_cnt",   32'(if0.xfer_count), 32'd1);
        chk("post_cnt2",  32'(if2.xfer_count), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
